// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: keyboard command/response codes, transmitter states, parity helper.
package ps2_pkg;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ECHO     = 8'hEE;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } tx_state_e;

    // Parity bit that makes the count of ones across data plus parity odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~(^d);
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Multi-stage synchronizer for one PS/2 line with falling-edge detect on the synchronized value.
module ps2_line_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic level,
    output logic fall_c
);

    localparam int unsigned DEPTH = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    // Extra stage past the synchronizer holds the previous synchronized value.
    logic [DEPTH:0] sr;

    // Reset to the idle-high line level so no edge is seen right after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '1;
        end else begin
            sr <= {sr[DEPTH-1:0], line};
        end
    end

    assign level  = sr[DEPTH-1];
    assign fall_c = sr[DEPTH] & ~sr[DEPTH-1];

endmodule

// File: rtl/ps2_transmitter.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, clocked-out frame,
// device acknowledge check and a watchdog covering the device-clocked part of the frame.
module ps2_transmitter #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_ack_err,
    output logic       tx_timeout
);

    import ps2_pkg::*;

    localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int unsigned WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned IDX_W = 4;

    tx_state_e        state_q, state_d;
    logic [7:0]       data_q, data_d;
    logic             par_q, par_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [INH_W-1:0] inh_q, inh_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             ack_err_q, ack_err_d;
    logic             clk_low_d, data_low_d;
    logic             done_d, done_err_d, timeout_d;
    logic             wd_expired;

    logic             clk_s, clk_fall;
    logic             data_s, data_fall_unused;

    ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
        .clk    (clk),
        .rst    (rst),
        .line   (ps2_clk_in),
        .level  (clk_s),
        .fall_c (clk_fall)
    );

    ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_data_sync (
        .clk    (clk),
        .rst    (rst),
        .line   (ps2_data_in),
        .level  (data_s),
        .fall_c (data_fall_unused)
    );

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q            <= IDLE;
            data_q             <= '0;
            par_q              <= 1'b0;
            idx_q              <= '0;
            inh_q              <= '0;
            wd_q               <= '0;
            ack_err_q          <= 1'b0;
            ps2_clk_drive_low  <= 1'b0;
            ps2_data_drive_low <= 1'b0;
            tx_ready           <= 1'b1;
            busy               <= 1'b0;
            tx_done            <= 1'b0;
            tx_ack_err         <= 1'b0;
            tx_timeout         <= 1'b0;
        end else begin
            state_q            <= state_d;
            data_q             <= data_d;
            par_q              <= par_d;
            idx_q              <= idx_d;
            inh_q              <= inh_d;
            wd_q               <= wd_d;
            ack_err_q          <= ack_err_d;
            ps2_clk_drive_low  <= clk_low_d;
            ps2_data_drive_low <= data_low_d;
            tx_ready           <= (state_d == IDLE);
            busy               <= (state_d != IDLE);
            tx_done            <= done_d;
            tx_ack_err         <= done_err_d;
            tx_timeout         <= timeout_d;
        end
    end

    assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        par_d      = par_q;
        idx_d      = idx_q;
        inh_d      = inh_q;
        wd_d       = wd_q;
        ack_err_d  = ack_err_q;
        clk_low_d  = ps2_clk_drive_low;
        data_low_d = ps2_data_drive_low;
        done_d     = 1'b0;
        done_err_d = 1'b0;
        timeout_d  = 1'b0;

        case (state_q)
            IDLE: begin
                clk_low_d  = 1'b0;
                data_low_d = 1'b0;
                if (tx_valid && tx_ready) begin
                    data_d    = tx_data;
                    par_d     = odd_parity(tx_data);
                    idx_d     = '0;
                    inh_d     = '0;
                    wd_d      = '0;
                    ack_err_d = 1'b0;
                    clk_low_d = 1'b1;
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_q == INH_W'(INHIBIT_CYCLES - 1)) begin
                    data_low_d = 1'b1;
                    state_d    = START;
                end else begin
                    inh_d = inh_q + INH_W'(1);
                end
            end
            START: begin
                clk_low_d  = 1'b0;
                data_low_d = 1'b1;
                idx_d      = '0;
                wd_d       = '0;
                state_d    = DATA;
            end
            DATA: begin
                wd_d = wd_q + WD_W'(1);
                if (clk_fall) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q < IDX_W'(8)) begin
                        data_low_d = ~data_q[idx_q[2:0]];
                    end else if (idx_q == IDX_W'(8)) begin
                        data_low_d = ~par_q;
                    end else begin
                        data_low_d = 1'b0;
                        state_d    = ACK;
                    end
                end
            end
            ACK: begin
                wd_d = wd_q + WD_W'(1);
                if (clk_fall) begin
                    ack_err_d = data_s;
                    state_d   = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                wd_d = wd_q + WD_W'(1);
                if (clk_s && data_s) begin
                    done_d     = 1'b1;
                    done_err_d = ack_err_q;
                    state_d    = IDLE;
                end
            end
            default: begin
                clk_low_d  = 1'b0;
                data_low_d = 1'b0;
                state_d    = IDLE;
            end
        endcase

        // Watchdog expiry overrides any completion in the same cycle.
        if ((state_q inside {DATA, ACK, WAIT_IDLE}) && wd_expired) begin
            clk_low_d  = 1'b0;
            data_low_d = 1'b0;
            done_d     = 1'b0;
            done_err_d = 1'b0;
            timeout_d  = 1'b1;
            state_d    = IDLE;
        end
    end

endmodule

// File: tb/tb_ps2_transmitter.sv
// Directed bench for ps2_transmitter with a wired-AND PS/2 device model (40-cycle half period).
module tb_ps2_transmitter;

    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_drive_low, ps2_data_drive_low;
    logic       busy, tx_done, tx_ack_err, tx_timeout;
    logic       dev_clk, dev_data;

    int checks = 0;
    int errors = 0;

    // Monitor state, written only by the monitor process.
    int       cyc = 0;
    int       done_cnt = 0;
    int       timeout_cnt = 0;
    int       stray_err = 0;
    int       inh_run = 0;
    int       st_run = 0;
    int       release_cyc = 0;
    int       timeout_cyc = 0;
    logic [1:0] prev_pat = 2'b00;

    typedef struct {
        logic [7:0] data;
        bit         ack;
        logic       exp_par;
        logic       exp_err;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    assign ps2_clk_in  = dev_clk  & ~ps2_clk_drive_low;
    assign ps2_data_in = dev_data & ~ps2_data_drive_low;

    ps2_transmitter #(
        .INHIBIT_CYCLES (10),
        .TIMEOUT_CYCLES (2000),
        .SYNC_STAGES    (2)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .tx_data            (tx_data),
        .tx_valid           (tx_valid),
        .tx_ready           (tx_ready),
        .ps2_clk_in         (ps2_clk_in),
        .ps2_data_in        (ps2_data_in),
        .ps2_clk_drive_low  (ps2_clk_drive_low),
        .ps2_data_drive_low (ps2_data_drive_low),
        .busy               (busy),
        .tx_done            (tx_done),
        .tx_ack_err         (tx_ack_err),
        .tx_timeout         (tx_timeout)
    );

    always @(negedge clk) begin
        logic [1:0] pat;
        pat = {ps2_clk_drive_low, ps2_data_drive_low};
        cyc <= cyc + 1;
        if (tx_done) done_cnt <= done_cnt + 1;
        if (tx_timeout) begin
            timeout_cnt <= timeout_cnt + 1;
            timeout_cyc <= cyc;
        end
        if (!tx_done && tx_ack_err) stray_err <= stray_err + 1;
        if (pat == 2'b10) inh_run <= (prev_pat == 2'b10) ? inh_run + 1 : 1;
        if (pat == 2'b11) st_run  <= (prev_pat == 2'b11) ? st_run + 1 : 1;
        if (prev_pat == 2'b11 && pat == 2'b01) release_cyc <= cyc;
        prev_pat <= pat;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        while (!tx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("accept_busy", 32'(busy), 32'd1);
    endtask

    // Waits for request-to-send, then clocks n_pulses falling edges, sampling data before each rise.
    task automatic device_frame(input bit do_ack, input int n_pulses,
                                output logic [9:0] bits, output bit ok);
        int n = 0;
        ok   = 1'b1;
        bits = '0;
        while (!(ps2_data_drive_low && !ps2_clk_drive_low) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            ok = 1'b0;
            return;
        end
        repeat (10) @(negedge clk);
        for (int k = 0; k < n_pulses; k++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            if (k < 10) bits[k] = ps2_data_in;
            dev_clk = 1'b1;
            if (k == 10) begin
                if (do_ack) begin
                    repeat (HALF / 2) @(negedge clk);
                    dev_data = 1'b1;
                end
            end else if (k == 9 && do_ack) begin
                repeat (HALF / 2) @(negedge clk);
                dev_data = 1'b0;
                repeat (HALF - HALF / 2) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
        end
    endtask

    task automatic wait_done(output bit seen, output logic err);
        seen = 1'b0;
        err  = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (tx_done) begin
                seen = 1'b1;
                err  = tx_ack_err;
                break;
            end
        end
    endtask

    task automatic run_vector(input logic [7:0] d, input bit ack, input logic par, input logic err);
        logic [9:0] bits;
        bit         ok, seen;
        logic       ae;
        int         d0;
        d0 = done_cnt;
        send(d);
        device_frame(ack, 11, bits, ok);
        check("rts_seen", 32'(ok), 32'd1);
        wait_done(seen, ae);
        check("done_seen", 32'(seen), 32'd1);
        check("ack_err", 32'(ae), 32'(err));
        check("data_bits", 32'(bits[7:0]), 32'(d));
        check("parity_bit", 32'(bits[8]), 32'(par));
        check("stop_bit", 32'(bits[9]), 32'd1);
        check("inhibit_len", 32'(inh_run), 32'd10);
        check("start_len", 32'(st_run), 32'd1);
        @(negedge clk);
        check("ready_after", 32'(tx_ready), 32'd1);
        check("one_done", 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        logic [9:0] b1, b2;
        bit         ok, seen;
        logic       ae;
        int         d0, t0, n;

        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        dev_clk  = 1'b1;
        dev_data = 1'b1;

        vecs[0] = '{8'hED, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'hEE, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'hF4, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{8'h01, 1'b1, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_clk_low", 32'(ps2_clk_drive_low), 32'd0);
        check("rst_data_low", 32'(ps2_data_drive_low), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_timeout", 32'(tx_timeout), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_vector(vecs[i].data, vecs[i].ack, vecs[i].exp_par, vecs[i].exp_err);
            repeat (5) @(negedge clk);
        end

        // Back-to-back with tx_valid held; second byte is changed only after the first accept.
        d0 = done_cnt;
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'h01;
        device_frame(1'b1, 11, b1, ok);
        wait_done(seen, ae);
        check("b2b_done1", 32'(seen), 32'd1);
        @(negedge clk);
        tx_valid = 1'b0;
        check("b2b_reaccept", 32'(busy), 32'd1);
        device_frame(1'b1, 11, b2, ok);
        wait_done(seen, ae);
        check("b2b_done2", 32'(seen), 32'd1);
        check("b2b_bits1", 32'(b1), 32'h300);
        check("b2b_bits2", 32'(b2), 32'h201);
        repeat (20) @(negedge clk);
        check("b2b_two_done", 32'(done_cnt - d0), 32'd2);

        // Device never clocks: watchdog fires 2000 cycles after clock release.
        d0 = done_cnt;
        t0 = timeout_cnt;
        send(8'hF4);
        seen = 1'b0;
        for (n = 0; n < 2500; n++) begin
            @(negedge clk);
            if (tx_timeout) begin
                seen = 1'b1;
                break;
            end
        end
        check("to_seen", 32'(seen), 32'd1);
        check("to_clk_rel", 32'(ps2_clk_drive_low), 32'd0);
        check("to_data_rel", 32'(ps2_data_drive_low), 32'd0);
        @(negedge clk);
        check("to_latency", 32'(timeout_cyc - release_cyc), 32'd2000);
        check("to_pulse", 32'(tx_timeout), 32'd0);
        check("to_ready", 32'(tx_ready), 32'd1);
        repeat (20) @(negedge clk);
        check("to_no_done", 32'(done_cnt - d0), 32'd0);
        check("to_count", 32'(timeout_cnt - t0), 32'd1);

        // Asynchronous reset mid-frame at idx=4 (d3 of 0xA5 is 0, so data is driven low).
        send(8'hA5);
        device_frame(1'b1, 4, b1, ok);
        check("mid_data_low", 32'(ps2_data_drive_low), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_clk_rel", 32'(ps2_clk_drive_low), 32'd0);
        check("arst_data_rel", 32'(ps2_data_drive_low), 32'd0);
        check("arst_ready", 32'(tx_ready), 32'd1);
        check("arst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        run_vector(8'hFF, 1'b1, 1'b1, 1'b0);

        // A request pulsed during an active frame is ignored.
        d0 = done_cnt;
        send(8'hF4);
        fork
            device_frame(1'b1, 11, b1, ok);
            begin
                repeat (300) @(negedge clk);
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        wait_done(seen, ae);
        check("busy_done", 32'(seen), 32'd1);
        check("busy_bits", 32'(b1), 32'h2F4);
        repeat (100) @(negedge clk);
        check("busy_one_done", 32'(done_cnt - d0), 32'd1);
        check("busy_idle", 32'(busy), 32'd0);

        check("no_stray_ack_err", 32'(stray_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
